// File: rtl/pe_xi_sad_param.sv
// pe_xi_sad_param: motion-estimation PE with CB bank, ref mux, |curr-ref| stage and per-CB saturating SAD
//   clk, rst                      clock, asynchronous active-high reset
//   in_curr/in_curr_enable/cb_wr_sel -> next_pix     chained current-block load
//   up_ref_1/up_ref_8/down_ref_1/down_ref_8, change_ref, ref_input_ctrl -> ref_pix
//   calc_valid, abs_sel -> abs_out, abs_valid        registered absolute difference
//   acc_clear, sad_rd_en, sad_rd_sel -> sad_out, sad_sat, sad_rd_valid
module pe_xi_sad_param #(
    parameter int PIXEL_W  = 8,
    parameter int NUM_CB   = 4,
    parameter int CB_SEL_W = 2,
    parameter int SAD_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIXEL_W-1:0]  in_curr,
    input  logic                in_curr_enable,
    input  logic [CB_SEL_W-1:0] cb_wr_sel,
    output logic [PIXEL_W-1:0]  next_pix,
    input  logic [PIXEL_W-1:0]  up_ref_1,
    input  logic [PIXEL_W-1:0]  up_ref_8,
    input  logic [PIXEL_W-1:0]  down_ref_1,
    input  logic [PIXEL_W-1:0]  down_ref_8,
    input  logic                change_ref,
    input  logic [1:0]          ref_input_ctrl,
    output logic [PIXEL_W-1:0]  ref_pix,
    input  logic                calc_valid,
    input  logic [CB_SEL_W-1:0] abs_sel,
    output logic [PIXEL_W-1:0]  abs_out,
    output logic                abs_valid,
    input  logic                acc_clear,
    input  logic                sad_rd_en,
    input  logic [CB_SEL_W-1:0] sad_rd_sel,
    output logic [SAD_W-1:0]    sad_out,
    output logic                sad_sat,
    output logic                sad_rd_valid
);
    if (CB_SEL_W != $clog2(NUM_CB)) begin : g_bad_sel
        $error("CB_SEL_W must equal $clog2(NUM_CB)");
    end
    if (SAD_W < PIXEL_W + 1) begin : g_bad_sad
        $error("SAD_W must be at least PIXEL_W+1");
    end
    logic [PIXEL_W-1:0]  cb [NUM_CB];
    logic [SAD_W-1:0]    acc [NUM_CB];
    logic [NUM_CB-1:0]   sat;
    logic [CB_SEL_W-1:0] abs_cb;
    logic [PIXEL_W-1:0]  src, cur, diff;
    logic [SAD_W:0]      sum;
    assign next_pix = cb[cb_wr_sel];
    always_comb begin
        src  = ref_input_ctrl == 2'd0 ? up_ref_1 :
               ref_input_ctrl == 2'd1 ? up_ref_8 :
               ref_input_ctrl == 2'd2 ? down_ref_1 : down_ref_8;
        cur  = cb[abs_sel];
        // max - min keeps the unsigned difference from wrapping
        diff = cur > ref_pix ? cur - ref_pix : ref_pix - cur;
        // extra top bit flags overflow of the accumulator
        sum  = {1'b0, acc[abs_cb]} + (SAD_W+1)'(abs_out);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CB; i++) cb[i] <= '0;
            ref_pix <= '0;
        end else begin
            if (in_curr_enable) cb[cb_wr_sel] <= in_curr;
            if (change_ref) ref_pix <= src;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_valid <= 1'b0;
            abs_out   <= '0;
            abs_cb    <= '0;
        end else begin
            abs_valid <= calc_valid;
            if (calc_valid) begin
                abs_out <= diff;
                abs_cb  <= abs_sel;
            end
        end
    end
    // a clear coinciding with a sample keeps that sample as the first of the new block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CB; i++) acc[i] <= '0;
            sat <= '0;
        end else begin
            for (int i = 0; i < NUM_CB; i++) begin
                if (abs_valid && abs_cb == CB_SEL_W'(i)) begin
                    acc[i] <= acc_clear ? SAD_W'(abs_out) : (sum[SAD_W] ? '1 : sum[SAD_W-1:0]);
                    sat[i] <= !acc_clear && (sat[i] || sum[SAD_W]);
                end else if (acc_clear) begin
                    acc[i] <= '0;
                    sat[i] <= 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sad_rd_valid <= 1'b0;
            sad_out      <= '0;
            sad_sat      <= 1'b0;
        end else begin
            sad_rd_valid <= sad_rd_en;
            if (sad_rd_en) begin
                sad_out <= acc[sad_rd_sel];
                sad_sat <= sat[sad_rd_sel];
            end
        end
    end
endmodule

// File: tb/tb_pe_xi_sad_param.sv
// tb_pe_xi_sad_param: randomized and directed bench against a behavioural SAD model
module tb_pe_xi_sad_param;
    localparam int PW = 8, NC = 4, SW = 2, AW = 9;
    localparam int MAXV = (1 << AW) - 1;
    logic clk = 0, rst = 1;
    logic [PW-1:0] in_curr = 0, up_ref_1 = 0, up_ref_8 = 0, down_ref_1 = 0, down_ref_8 = 0;
    logic in_curr_enable = 0, change_ref = 0, calc_valid = 0, acc_clear = 0, sad_rd_en = 0;
    logic [SW-1:0] cb_wr_sel = 0, abs_sel = 0, sad_rd_sel = 0;
    logic [1:0] ref_input_ctrl = 0;
    logic [PW-1:0] next_pix, ref_pix, abs_out;
    logic [AW-1:0] sad_out;
    logic abs_valid, sad_sat, sad_rd_valid;
    int total = 0, bad = 0;
    int m_cb[NC], m_acc[NC], m_sat[NC];
    int m_ref, m_abs, m_absv, m_abscb, m_sad, m_ssat, m_rdv;
    pe_xi_sad_param #(.PIXEL_W(PW), .NUM_CB(NC), .CB_SEL_W(SW), .SAD_W(AW)) dut (
        .clk(clk), .rst(rst), .in_curr(in_curr), .in_curr_enable(in_curr_enable),
        .cb_wr_sel(cb_wr_sel), .next_pix(next_pix), .up_ref_1(up_ref_1), .up_ref_8(up_ref_8),
        .down_ref_1(down_ref_1), .down_ref_8(down_ref_8), .change_ref(change_ref),
        .ref_input_ctrl(ref_input_ctrl), .ref_pix(ref_pix), .calc_valid(calc_valid),
        .abs_sel(abs_sel), .abs_out(abs_out), .abs_valid(abs_valid), .acc_clear(acc_clear),
        .sad_rd_en(sad_rd_en), .sad_rd_sel(sad_rd_sel), .sad_out(sad_out), .sad_sat(sad_sat),
        .sad_rd_valid(sad_rd_valid));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        foreach (m_cb[i]) begin m_cb[i] = 0; m_acc[i] = 0; m_sat[i] = 0; end
        m_ref = 0; m_abs = 0; m_absv = 0; m_abscb = 0; m_sad = 0; m_ssat = 0; m_rdv = 0;
    endtask
    task automatic model_step();
        int d, s;
        if (sad_rd_en) begin m_sad = m_acc[sad_rd_sel]; m_ssat = m_sat[sad_rd_sel]; end
        m_rdv = sad_rd_en;
        if (acc_clear) begin
            foreach (m_acc[i]) begin m_acc[i] = 0; m_sat[i] = 0; end
            if (m_absv != 0) m_acc[m_abscb] = m_abs;
        end else if (m_absv != 0) begin
            s = m_acc[m_abscb] + m_abs;
            if (s > MAXV) begin m_acc[m_abscb] = MAXV; m_sat[m_abscb] = 1; end
            else m_acc[m_abscb] = s;
        end
        m_absv = calc_valid;
        if (calc_valid) begin
            d = m_cb[abs_sel] - m_ref;
            m_abs = d < 0 ? -d : d;
            m_abscb = abs_sel;
        end
        if (in_curr_enable) m_cb[cb_wr_sel] = in_curr;
        if (change_ref) begin
            case (ref_input_ctrl)
                2'd0: m_ref = up_ref_1;
                2'd1: m_ref = up_ref_8;
                2'd2: m_ref = down_ref_1;
                default: m_ref = down_ref_8;
            endcase
        end
    endtask
    always @(posedge clk) if (rst) model_reset(); else model_step();
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("next_pix", next_pix, m_cb[cb_wr_sel]);
        chk("ref_pix", ref_pix, m_ref);
        chk("abs_out", abs_out, m_abs);
        chk("abs_valid", abs_valid, m_absv);
        chk("sad_out", sad_out, m_sad);
        chk("sad_sat", sad_sat, m_ssat);
        chk("sad_rd_valid", sad_rd_valid, m_rdv);
    endtask
    task automatic idle();
        in_curr_enable = 0; change_ref = 0; calc_valid = 0; acc_clear = 0; sad_rd_en = 0;
    endtask
    task automatic load(input int slot, input int v);
        in_curr_enable = 1; cb_wr_sel = SW'(slot); in_curr = PW'(v);
        tick();
        in_curr_enable = 0;
    endtask
    task automatic set_ref0(input int v);
        up_ref_1 = PW'(v); change_ref = 1; ref_input_ctrl = 0;
        tick();
        change_ref = 0;
    endtask
    task automatic rd(input int slot, input int exp_sad, input int exp_sat);
        sad_rd_en = 1; sad_rd_sel = SW'(slot);
        tick();
        sad_rd_en = 0;
        chk("rd_sad", sad_out, exp_sad);
        chk("rd_sat", sad_sat, exp_sat);
        chk("rd_valid", sad_rd_valid, 1);
    endtask
    initial begin
        int e[4];
        e = '{15, 5, 5, 15};
        @(negedge clk);
        chk("rst_abs_valid", abs_valid, 0);
        chk("rst_sad_rd_valid", sad_rd_valid, 0);
        chk("rst_sad_out", sad_out, 0);
        chk("rst_ref_pix", ref_pix, 0);
        rst = 0;
        // load chain and abs against ref 25
        for (int i = 0; i < 4; i++) load(i, 10 * (i + 1));
        for (int i = 0; i < 4; i++) begin
            cb_wr_sel = SW'(i);
            #1 chk("next_pix_slot", next_pix, 10 * (i + 1));
        end
        set_ref0(25);
        for (int i = 0; i < 4; i++) begin
            calc_valid = 1; abs_sel = SW'(i);
            tick();
            chk("abs_t2", abs_out, e[i]);
            chk("abs_valid_t2", abs_valid, 1);
        end
        idle(); acc_clear = 1;
        tick();
        idle();
        // reference mux
        up_ref_1 = 1; up_ref_8 = 2; down_ref_1 = 3; down_ref_8 = 4;
        for (int c = 0; c < 4; c++) begin
            change_ref = 1; ref_input_ctrl = 2'(c);
            tick();
            chk("ref_mux", ref_pix, c + 1);
        end
        change_ref = 0; ref_input_ctrl = 0;
        tick();
        chk("ref_hold", ref_pix, 4);
        // 64 samples of 7 on slot 2
        load(2, 10); set_ref0(3);
        acc_clear = 1; tick(); acc_clear = 0;
        for (int i = 0; i < 64; i++) begin calc_valid = 1; abs_sel = 2; tick(); end
        calc_valid = 0; tick();
        for (int i = 0; i < 4; i++) rd(i, i == 2 ? 448 : 0, 0);
        // saturation
        load(0, 255); set_ref0(0);
        acc_clear = 1; tick(); acc_clear = 0;
        for (int i = 0; i < 3; i++) begin calc_valid = 1; abs_sel = 0; tick(); end
        calc_valid = 0; tick();
        rd(0, 511, 1);
        acc_clear = 1; tick(); acc_clear = 0;
        rd(0, 0, 0);
        // collisions: slot 1 holds 20, ref 0
        in_curr_enable = 1; cb_wr_sel = 1; in_curr = 99; calc_valid = 1; abs_sel = 1;
        tick();
        chk("col_old_cb", abs_out, 20);
        in_curr_enable = 0; calc_valid = 0; acc_clear = 1;
        tick();
        acc_clear = 0;
        rd(1, 20, 0);
        calc_valid = 1; abs_sel = 1;
        tick();
        calc_valid = 0;
        rd(1, 20, 0);
        rd(1, 119, 0);
        // asynchronous reset mid-accumulation
        for (int i = 0; i < 5; i++) begin calc_valid = 1; abs_sel = 1; tick(); end
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_abs_valid", abs_valid, 0);
        chk("arst_abs_out", abs_out, 0);
        chk("arst_ref_pix", ref_pix, 0);
        chk("arst_next_pix", next_pix, 0);
        chk("arst_sad_out", sad_out, 0);
        chk("arst_sad_sat", sad_sat, 0);
        chk("arst_rd_valid", sad_rd_valid, 0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        rd(1, 0, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_curr = PW'($urandom); in_curr_enable = 1'($urandom);
            cb_wr_sel = SW'($urandom); abs_sel = SW'($urandom); sad_rd_sel = SW'($urandom);
            up_ref_1 = PW'($urandom); up_ref_8 = PW'($urandom);
            down_ref_1 = PW'($urandom); down_ref_8 = PW'($urandom);
            change_ref = $urandom_range(0, 3) == 0; ref_input_ctrl = 2'($urandom);
            calc_valid = $urandom_range(0, 3) != 0; sad_rd_en = 1'($urandom);
            acc_clear = $urandom_range(0, 7) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
